// File: rtl/rob_pr_free_q.sv
// Commit-bundle queue between ROB commit and the banked free list.
// Drains the head bundle one PR per bank per cycle and retires it once every lane has drained.
module rob_pr_free_q #(
   parameter int unsigned ENTRIES    = 2,
   parameter int unsigned LANES      = 4,
   parameter int unsigned PR_COUNT   = 128,
   parameter int unsigned BANK_COUNT = 4,
   localparam int unsigned LOG_PR_COUNT = $clog2(PR_COUNT),
   localparam int unsigned LOG_BANK     = $clog2(BANK_COUNT),
   localparam int unsigned IDX_W        = LOG_PR_COUNT - LOG_BANK
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            enq_valid,
   input  logic [LANES-1:0]                enq_valid_by_lane,
   input  logic [LANES*LOG_PR_COUNT-1:0]   enq_PR_by_lane,
   output logic                            enq_ready,
   output logic [BANK_COUNT-1:0]           deq_valid_by_bank,
   output logic [BANK_COUNT*IDX_W-1:0]     deq_PR_by_bank,
   input  logic [BANK_COUNT-1:0]           deq_ready_by_bank
);

   localparam int unsigned PTR_W  = $clog2(ENTRIES);
   localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);
   localparam int unsigned LANE_W = $clog2(LANES);

   logic [LOG_PR_COUNT-1:0] pr_q   [ENTRIES][LANES];
   logic [LANES-1:0]        pend_q [ENTRIES];
   logic [PTR_W-1:0]        head_q;
   logic [PTR_W-1:0]        tail_q;
   logic [CNT_W-1:0]        count_q;

   logic                    not_empty;
   logic [LANES-1:0]        head_pend;
   logic [LANES-1:0]        clr;
   logic [LANES-1:0]        head_pend_next;
   logic [BANK_COUNT-1:0]   hit;
   logic [LANE_W-1:0]       sel [BANK_COUNT];
   logic                    enq_fire;
   logic                    alloc;
   logic                    retire;

   assign not_empty = (count_q != '0);
   assign enq_ready = (count_q < CNT_W'(ENTRIES));
   assign enq_fire  = enq_valid && enq_ready;
   assign alloc     = enq_fire && (|enq_valid_by_lane);

   // Per bank, pick the lowest pending head lane mapped to it; ready only affects the clear mask.
   always_comb begin
      head_pend         = pend_q[head_q];
      hit               = '0;
      clr               = '0;
      deq_valid_by_bank = '0;
      deq_PR_by_bank    = '0;
      for (int unsigned b = 0; b < BANK_COUNT; b++) begin
         sel[b] = '0;
         for (int unsigned l = 0; l < LANES; l++) begin
            if (!hit[b] && not_empty && head_pend[l] &&
                (pr_q[head_q][l][LOG_BANK-1:0] == LOG_BANK'(b))) begin
               hit[b] = 1'b1;
               sel[b] = LANE_W'(l);
            end
         end
         if (hit[b]) begin
            deq_valid_by_bank[b]             = 1'b1;
            deq_PR_by_bank[b*IDX_W +: IDX_W] = pr_q[head_q][sel[b]][LOG_PR_COUNT-1:LOG_BANK];
            if (deq_ready_by_bank[b]) begin
               clr[sel[b]] = 1'b1;
            end
         end
      end
      head_pend_next = head_pend & ~clr;
   end

   assign retire = not_empty && (head_pend_next == '0);

   // Control state: pointers, occupancy and pending masks.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned e = 0; e < ENTRIES; e++) begin
            pend_q[e] <= '0;
         end
      end else begin
         if (not_empty) begin
            pend_q[head_q] <= head_pend_next;
         end
         // Allocation never targets the draining head: tail==head only when empty or full.
         if (alloc) begin
            pend_q[tail_q] <= enq_valid_by_lane;
            tail_q         <= tail_q + PTR_W'(1);
         end
         if (retire) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({alloc, retire})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // PR payload storage needs no reset; pending masks gate every use.
   always_ff @(posedge CLK) begin
      if (alloc) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            pr_q[tail_q][l] <= enq_PR_by_lane[l*LOG_PR_COUNT +: LOG_PR_COUNT];
         end
      end
   end

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Directed bench for rob_pr_free_q: a scoreboard of per-bank expected PR indices is
// filled as bundles are issued and emptied by a monitor watching bank handshakes.
module tb_rob_pr_free_q;

   localparam int unsigned LANES = 4;
   localparam int unsigned NB    = 4;
   localparam int unsigned PRW   = 7;
   localparam int unsigned IW    = 5;

   logic                  CLK = 1'b0;
   logic                  nRST;
   logic                  enq_valid;
   logic [LANES-1:0]      enq_valid_by_lane;
   logic [LANES*PRW-1:0]  enq_PR_by_lane;
   logic                  enq_ready;
   logic [NB-1:0]         deq_valid_by_bank;
   logic [NB*IW-1:0]      deq_PR_by_bank;
   logic [NB-1:0]         deq_ready_by_bank;

   rob_pr_free_q dut (
      .CLK               (CLK),
      .nRST              (nRST),
      .enq_valid         (enq_valid),
      .enq_valid_by_lane (enq_valid_by_lane),
      .enq_PR_by_lane    (enq_PR_by_lane),
      .enq_ready         (enq_ready),
      .deq_valid_by_bank (deq_valid_by_bank),
      .deq_PR_by_bank    (deq_PR_by_bank),
      .deq_ready_by_bank (deq_ready_by_bank)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int bank;
      int idx;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic mon_en = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
      else n_pass++;
   endfunction

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Drive one bundle; when it is expected to be accepted, queue its PRs in lane order.
   task automatic load(input logic [3:0] m, input int p0, input int p1, input int p2,
                       input int p3, input bit accept);
      int p[4];
      p = '{p0, p1, p2, p3};
      enq_valid         = 1'b1;
      enq_valid_by_lane = m;
      for (int l = 0; l < 4; l++) begin
         enq_PR_by_lane[l*PRW +: PRW] = PRW'(p[l]);
         if (accept && m[l]) sb.push_back('{p[l] % 4, p[l] / 4});
      end
   endtask

   // Monitor: every bank handshake must match the oldest outstanding entry for that bank.
   int         k;
   logic [4:0] got;
   always @(negedge CLK) begin
      if (mon_en && nRST) begin
         for (int b = 0; b < 4; b++) begin
            got = deq_PR_by_bank[b*IW +: IW];
            if (deq_valid_by_bank[b] && deq_ready_by_bank[b]) begin
               k = -1;
               for (int i = 0; i < sb.size(); i++)
                  if (k < 0 && sb[i].bank == b) k = i;
               if (k < 0) begin
                  n_chk++;
                  $display("FAIL sb_unexpected bank%0d: got %0d required no transfer", b, got);
               end else begin
                  chk($sformatf("sb_bank%0d", b), 32'(got), 32'(sb[k].idx));
                  sb.delete(k);
               end
            end else if (!deq_valid_by_bank[b]) begin
               chk($sformatf("idle_pr_zero_bank%0d", b), 32'(got), 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  exp_bank[5];
      nRST              = 1'b0;
      enq_valid         = 1'b1;
      enq_valid_by_lane = 4'b1111;
      enq_PR_by_lane    = '0;
      deq_ready_by_bank = 4'b1111;

      // Reset held two cycles while a bundle is presented.
      cyc();
      mon_en = 1'b1;
      cyc();
      nRST      = 1'b1;
      enq_valid = 1'b0;
      chk("rst_enq_ready", 32'(enq_ready), 32'd1);
      chk("rst_deq_valid", 32'(deq_valid_by_bank), 32'd0);
      chk("rst_deq_pr", 32'(deq_PR_by_bank), 32'd0);
      cyc();
      chk("rst_no_alloc", 32'(deq_valid_by_bank), 32'd0);

      // Distinct banks: one-cycle latency, full throughput.
      load(4'b1111, 4, 9, 14, 3, 1'b1);
      chk("dist_enq_ready", 32'(enq_ready), 32'd1);
      cyc();
      enq_valid = 1'b0;
      chk("dist_valid", 32'(deq_valid_by_bank), 32'hF);
      chk("dist_pr", 32'(deq_PR_by_bank), 32'({5'd0, 5'd3, 5'd2, 5'd1}));
      cyc();
      chk("dist_empty_valid", 32'(deq_valid_by_bank), 32'd0);
      chk("dist_empty_ready", 32'(enq_ready), 32'd1);

      // Bank collision: three lanes to bank 0 serialise in lane order.
      load(4'b1111, 8, 12, 16, 5, 1'b1);
      cyc();
      enq_valid = 1'b0;
      chk("coll_c1_valid", 32'(deq_valid_by_bank), 32'b0011);
      chk("coll_c1_b0", 32'(deq_PR_by_bank[0 +: IW]), 32'd2);
      chk("coll_c1_b1", 32'(deq_PR_by_bank[IW +: IW]), 32'd1);
      cyc();
      chk("coll_c2_valid", 32'(deq_valid_by_bank), 32'b0001);
      chk("coll_c2_b0", 32'(deq_PR_by_bank[0 +: IW]), 32'd3);
      cyc();
      chk("coll_c3_valid", 32'(deq_valid_by_bank), 32'b0001);
      chk("coll_c3_b0", 32'(deq_PR_by_bank[0 +: IW]), 32'd4);
      cyc();
      chk("coll_retired", 32'(deq_valid_by_bank), 32'd0);

      // Full queue under backpressure, partial drain, then release.
      deq_ready_by_bank = 4'b0000;
      load(4'b0011, 1, 2, 0, 0, 1'b1);
      chk("full_a_ready", 32'(enq_ready), 32'd1);
      cyc();
      load(4'b0001, 4, 0, 0, 0, 1'b1);
      chk("full_b_ready", 32'(enq_ready), 32'd1);
      cyc();
      load(4'b0001, 7, 0, 0, 0, 1'b0);
      chk("full_c_blocked", 32'(enq_ready), 32'd0);
      cyc();
      enq_valid = 1'b0;
      chk("full_head_a", 32'(deq_valid_by_bank), 32'b0110);
      chk("full_still_full", 32'(enq_ready), 32'd0);
      deq_ready_by_bank = 4'b0010;
      cyc();
      chk("stall_other_bank", 32'(deq_valid_by_bank), 32'b0100);
      chk("stall_no_retire", 32'(enq_ready), 32'd0);
      deq_ready_by_bank = 4'b1111;
      cyc();
      chk("full_ready_after_retire", 32'(enq_ready), 32'd1);
      chk("full_head_b", 32'(deq_valid_by_bank), 32'b0001);
      chk("full_head_b_pr", 32'(deq_PR_by_bank[0 +: IW]), 32'd1);
      cyc();
      chk("full_drained", 32'(deq_valid_by_bank), 32'd0);

      // Empty lane mask allocates nothing.
      deq_ready_by_bank = 4'b0000;
      load(4'b0000, 9, 9, 9, 9, 1'b0);
      chk("empty_enq_ready", 32'(enq_ready), 32'd1);
      cyc();
      chk("empty_no_alloc", 32'(deq_valid_by_bank), 32'd0);
      load(4'b0001, 6, 0, 0, 0, 1'b1);
      cyc();
      enq_valid = 1'b0;
      chk("empty_count_one", 32'(enq_ready), 32'd1);
      chk("empty_head", 32'(deq_valid_by_bank), 32'b0100);
      deq_ready_by_bank = 4'b1111;
      cyc();
      chk("empty_drained", 32'(deq_valid_by_bank), 32'd0);

      // Stream across pointer wrap; enqueue and retire share each edge at count 1.
      exp_bank = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
         load(4'b0001, i + 1, 0, 0, 0, 1'b1);
         chk($sformatf("wrap_ready_%0d", i), 32'(enq_ready), 32'd1);
         cyc();
         chk($sformatf("wrap_head_%0d", i), 32'(deq_valid_by_bank), 32'd1 << exp_bank[i]);
      end
      enq_valid = 1'b0;
      cyc();
      chk("wrap_drained", 32'(deq_valid_by_bank), 32'd0);
      cyc();
      chk("sb_all_seen", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
